// File: rtl/chacha_pkg.sv
// Shared widths, block size default and state encodings for the ChaCha
// byte-serial host link.
package chacha_pkg;

  localparam int BYTE_W              = 8;
  localparam int WORD_W              = 32;
  localparam int BYTES_PER_WORD      = WORD_W / BYTE_W;
  localparam int IDX_W               = $clog2(BYTES_PER_WORD);
  localparam int BLOCK_WORDS_DEFAULT = 16;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/chacha_rx_packer.sv
// Reassembles the core's LSB-first byte stream into 32-bit words and holds
// each word until the downstream consumer takes it.
module chacha_rx_packer
  import chacha_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_fire
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    rx_ready  = 1'b0;
    out_valid = 1'b0;
    out_fire  = 1'b0;
    if (flush) begin
      state_d = RX_COLLECT;
      idx_d   = '0;
    end else begin
      case (state_q)
        RX_COLLECT: begin
          rx_ready = 1'b1;
          if (rx_valid) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
              if (idx_q == IDX_W'(i)) word_d[i*BYTE_W +: BYTE_W] = rx_byte;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = RX_HOLD;
          end
        end
        RX_HOLD: begin
          out_valid = 1'b1;
          if (out_ready) begin
            out_fire = 1'b1;
            state_d  = RX_COLLECT;
            idx_d    = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign out_word = word_q;

endmodule

// File: rtl/chacha_byte_host.sv
// Word-to-byte serializer towards the ChaCha core plus byte-to-word return
// path with per-block last-word flagging.
module chacha_byte_host
  import chacha_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] in_word,
  input  logic        in_key,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_key,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int               CNT_W    = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  tx_state_e         tx_state_q, tx_state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              key_q, key_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_fire;
  logic              key_accept;

  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    key_d      = key_q;
    tx_idx_d   = tx_idx_q;
    in_ready   = 1'b0;
    if (flush) begin
      tx_state_d = TX_IDLE;
      tx_idx_d   = '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            shift_d    = in_word;
            key_d      = in_key;
            tx_idx_d   = '0;
            tx_state_d = TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            shift_d  = shift_q >> BYTE_W;
            tx_idx_d = tx_idx_q + 1'b1;
            if (tx_idx_q == LAST_IDX) tx_state_d = TX_IDLE;
          end
        end
      endcase
    end
  end

  // Byte outputs come straight from flops so the core sees glitch-free pins.
  assign tx_valid = (tx_state_q == TX_SEND);
  assign tx_byte  = shift_q[BYTE_W-1:0];
  assign tx_key   = key_q;

  assign key_accept = in_valid & in_ready & in_key;

  // A key word starts a fresh block even if a word is consumed the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (flush || key_accept) cnt_d = '0;
    else if (out_fire)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      shift_q    <= '0;
      key_q      <= 1'b0;
      tx_idx_q   <= '0;
      cnt_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      shift_q    <= shift_d;
      key_q      <= key_d;
      tx_idx_q   <= tx_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  chacha_rx_packer u_rx_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fire  (out_fire)
  );

  assign out_last = out_valid & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_chacha_byte_host.sv
// Self-checking bench for chacha_byte_host: directed scenarios plus a
// randomized run against a queue-based model of the byte link.
module tb_chacha_byte_host;

  localparam int BW = 16;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_word;
  logic        in_key;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_byte;
  logic        tx_key;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int tests = 0;
  int fails = 0;

  chacha_byte_host #(.BLOCK_WORDS(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_word   (in_word),
    .in_key    (in_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_byte   (tx_byte),
    .tx_key    (tx_key),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 1'b0; in_valid = 1'b0; in_key = 1'b0; in_word = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_byte = '0; out_ready = 1'b0;
  endtask

  // Drives four bytes of w, LSB first, assuming the packer is collecting.
  task automatic rx_push(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1'b1;
      rx_byte  = w[8*k +: 8];
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    tests++; if (tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    tests++; if (tx_key !== 1'b0) begin fails++; $display("FAIL reset_tx_key: got %b want 0", tx_key); end
    tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_word !== 32'h0) begin fails++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    $display("[TB] reset checked");
  endtask

  task automatic test_tx_single;
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    in_word = w; in_key = 1'b0; in_valid = 1'b1; tx_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL tx_single_accept: in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if ({tx_valid, tx_key, tx_byte} !== {1'b1, 1'b0, w[8*k +: 8]})
        begin fails++; $display("FAIL tx_single_byte%0d: valid/key/byte got %b/%b/%h want 1/0/%h", k, tx_valid, tx_key, tx_byte, w[8*k +: 8]); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL tx_single_busy%0d: in_ready got %b want 0", k, in_ready); end
      tick();
    end
    #1;
    tests++; if ({in_ready, tx_valid} !== 2'b10) begin fails++; $display("FAIL tx_single_done: in_ready/tx_valid got %b/%b want 1/0", in_ready, tx_valid); end
    $display("[TB] tx single word %h sent", w);
  endtask

  task automatic test_tx_key_stall;
    logic [31:0] kw;
    int ep, cyc;
    kw = 32'h03020100;
    in_word = kw; in_key = 1'b1; in_valid = 1'b1; tx_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0; in_key = 1'b0;
    ep = 0; cyc = 0;
    while (ep < 4 && cyc < 20) begin
      tx_ready = (cyc % 2 == 0);
      #1;
      tests++; if ({tx_valid, tx_key, tx_byte} !== {1'b1, 1'b1, kw[8*ep +: 8]})
        begin fails++; $display("FAIL tx_key_stall_c%0d: valid/key/byte got %b/%b/%h want 1/1/%h", cyc, tx_valid, tx_key, tx_byte, kw[8*ep +: 8]); end
      if (tx_ready) ep++;
      cyc++;
      tick();
    end
    tests++; if (ep != 4) begin fails++; $display("FAIL tx_key_stall_timeout: bytes %0d want 4", ep); end
    #1;
    tests++; if ({in_ready, tx_valid} !== 2'b10) begin fails++; $display("FAIL tx_key_stall_done: in_ready/tx_valid got %b/%b want 1/0", in_ready, tx_valid); end
    tx_ready = 1'b0;
    $display("[TB] tx key word %h sent with stalls over %0d cycles", kw, cyc);
  endtask

  task automatic test_rx_hold;
    logic [31:0] w;
    w = 32'h44332211;
    out_ready = 1'b0;
    rx_push(w);
    #1;
    tests++; if ({out_valid, rx_ready, out_last} !== 3'b100) begin fails++; $display("FAIL rx_hold_valid: valid/rx_ready/last got %b/%b/%b want 1/0/0", out_valid, rx_ready, out_last); end
    tests++; if (out_word !== w) begin fails++; $display("FAIL rx_hold_word: got %h want %h", out_word, w); end
    rx_valid = 1'b1; rx_byte = 8'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      tests++; if ({out_valid, rx_ready} !== 2'b10 || out_word !== w)
        begin fails++; $display("FAIL rx_hold_stall%0d: valid/rx_ready/word got %b/%b/%h want 1/0/%h", c, out_valid, rx_ready, out_word, w); end
    end
    rx_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    tests++; if ({out_valid, rx_ready} !== 2'b01) begin fails++; $display("FAIL rx_hold_consumed: valid/rx_ready got %b/%b want 0/1", out_valid, rx_ready); end
    $display("[TB] rx word %h held and consumed", w);
  endtask

  task automatic test_block_last;
    logic [31:0] w;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int n = 0; n < BW + 1; n++) begin
      w = $urandom;
      rx_push(w);
      #1;
      tests++; if ({out_valid, out_last} !== {1'b1, n == BW - 1} || out_word !== w)
        begin fails++; $display("FAIL block_word%0d: valid/last/word got %b/%b/%h want 1/%b/%h", n, out_valid, out_last, out_word, n == BW - 1, w); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      $display("[TB] block word %0d = %h last=%b", n, out_word, out_last);
    end
  endtask

  task automatic test_flush;
    logic [31:0] tw, rw, w;
    tw = $urandom; rw = $urandom;
    in_word = tw; in_key = 1'b0; in_valid = 1'b1; tx_ready = 1'b1;
    rx_valid = 1'b1; rx_byte = rw[7:0];
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      rx_byte = rw[8*k +: 8];
      #1;
      tests++; if (tx_byte !== tw[8*(k-1) +: 8]) begin fails++; $display("FAIL flush_pre_byte%0d: got %h want %h", k - 1, tx_byte, tw[8*(k-1) +: 8]); end
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; rx_byte = 8'h5A;
    #1;
    tests++; if ({in_ready, rx_ready, out_valid} !== 3'b000) begin fails++; $display("FAIL flush_cycle: in_ready/rx_ready/out_valid got %b/%b/%b want 0/0/0", in_ready, rx_ready, out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0; rx_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if ({tx_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL flush_tx_idle%0d: tx_valid/in_ready got %b/%b want 0/1", c, tx_valid, in_ready); end
      tick();
    end
    // Counter was non-zero before the flush, so last must land on word BW-1.
    for (int n = 0; n < BW + 3; n++) begin
      w = $urandom;
      rx_push(w);
      #1;
      tests++; if ({out_valid, out_last} !== {1'b1, n == BW - 1} || out_word !== w)
        begin fails++; $display("FAIL flush_word%0d: valid/last/word got %b/%b/%h want 1/%b/%h", n, out_valid, out_last, out_word, n == BW - 1, w); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    in_word = $urandom; in_key = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_key = 1'b0;
    repeat (5) tick();
    for (int n = 0; n < BW; n++) begin
      w = $urandom;
      rx_push(w);
      #1;
      tests++; if ({out_valid, out_last} !== {1'b1, n == BW - 1} || out_word !== w)
        begin fails++; $display("FAIL key_clear_word%0d: valid/last/word got %b/%b/%h want 1/%b/%h", n, out_valid, out_last, out_word, n == BW - 1, w); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    tx_ready = 1'b0;
    $display("[TB] flush and key-clear sequence done");
  endtask

  task automatic test_async_reset;
    logic [31:0] w, rw;
    w = $urandom; rw = $urandom;
    in_word = w; in_key = 1'b1; in_valid = 1'b1; tx_ready = 1'b1;
    rx_valid = 1'b1; rx_byte = 8'hEE;
    tick();
    tick();
    #1;
    tests++; if ({tx_valid, tx_key} !== 2'b11) begin fails++; $display("FAIL areset_pre: tx_valid/tx_key got %b/%b want 1/1", tx_valid, tx_key); end
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    tests++; if ({tx_valid, tx_key, tx_byte} !== 10'b0) begin fails++; $display("FAIL areset_tx: valid/key/byte got %b/%b/%h want 0/0/00", tx_valid, tx_key, tx_byte); end
    tests++; if ({in_ready, rx_ready, out_valid, out_last} !== 4'b1100) begin fails++; $display("FAIL areset_ctl: in_ready/rx_ready/out_valid/out_last got %b/%b/%b/%b want 1/1/0/0", in_ready, rx_ready, out_valid, out_last); end
    tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL areset_hold: tx_valid got %b want 0", tx_valid); end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if ({tx_valid, tx_key, tx_byte} !== {1'b1, 1'b1, w[8*k +: 8]})
        begin fails++; $display("FAIL areset_resend%0d: valid/key/byte got %b/%b/%h want 1/1/%h", k, tx_valid, tx_key, tx_byte, w[8*k +: 8]); end
      tick();
    end
    in_key = 1'b0;
    rx_push(rw);
    #1;
    tests++; if ({out_valid, out_word} !== {1'b1, rw}) begin fails++; $display("FAIL areset_rx: valid/word got %b/%h want 1/%h", out_valid, out_word, rw); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tx_ready = 1'b0;
    $display("[TB] async reset mid-send, word %h resent", w);
  endtask

  task automatic test_random;
    logic [7:0]  txq[$];
    logic        txk[$];
    logic [7:0]  rxb[$];
    logic [31:0] pend_word;
    bit          pending, busy, exp_in_ready, exp_ov;
    int          blk, words;
    flush = 1'b1; tick(); flush = 1'b0;
    pending = 1'b0; blk = 0; words = 0; pend_word = '0;
    for (int c = 0; c < 800; c++) begin
      flush     = ($urandom_range(0, 63) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      in_key    = ($urandom_range(0, 5) == 0);
      tx_ready  = ($urandom_range(0, 3) != 0);
      rx_valid  = ($urandom_range(0, 3) != 0);
      rx_byte   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      busy = (txq.size() != 0);
      exp_in_ready = !busy && !flush;
      exp_ov = pending && !flush;
      tests++; if (tx_valid !== busy) begin fails++; $display("FAIL rand_c%0d_tx_valid: got %b want %b", c, tx_valid, busy); end
      if (busy) begin
        tests++; if ({tx_key, tx_byte} !== {txk[0], txq[0]}) begin fails++; $display("FAIL rand_c%0d_tx_byte: key/byte got %b/%h want %b/%h", c, tx_key, tx_byte, txk[0], txq[0]); end
      end
      tests++; if (in_ready !== exp_in_ready) begin fails++; $display("FAIL rand_c%0d_in_ready: got %b want %b", c, in_ready, exp_in_ready); end
      tests++; if (rx_ready !== (!pending && !flush)) begin fails++; $display("FAIL rand_c%0d_rx_ready: got %b want %b", c, rx_ready, !pending && !flush); end
      tests++; if ({out_valid, out_last} !== {exp_ov, exp_ov && blk == BW - 1}) begin fails++; $display("FAIL rand_c%0d_out: valid/last got %b/%b want %b/%b", c, out_valid, out_last, exp_ov, exp_ov && blk == BW - 1); end
      if (pending) begin
        tests++; if (out_word !== pend_word) begin fails++; $display("FAIL rand_c%0d_out_word: got %h want %h", c, out_word, pend_word); end
      end
      if (flush) begin
        txq.delete(); txk.delete(); rxb.delete(); pending = 1'b0; blk = 0;
      end else begin
        if (busy && tx_ready) begin void'(txq.pop_front()); void'(txk.pop_front()); end
        if (exp_in_ready && in_valid) begin
          for (int k = 0; k < 4; k++) begin txq.push_back(in_word[8*k +: 8]); txk.push_back(in_key); end
        end
        if (pending && out_ready) begin
          pending = 1'b0; blk = (blk + 1) % BW; words++;
        end else if (!pending && rx_valid) begin
          rxb.push_back(rx_byte);
          if (rxb.size() == 4) begin
            pend_word = {rxb[3], rxb[2], rxb[1], rxb[0]};
            rxb.delete();
            pending = 1'b1;
          end
        end
        if (exp_in_ready && in_valid && in_key) blk = 0;
      end
      tick();
    end
    idle_inputs();
    $display("[TB] random run done, %0d words consumed", words);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    tick();
    test_tx_single();
    test_tx_key_stall();
    test_rx_hold();
    test_block_last();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chacha_byte_host.md
# chacha_byte_host

Host-side initiator for the ChaCha core's byte-serial link. It accepts 32-bit words (key or plaintext) from the SoC side and serializes them LSB-first into the core's byte input handshake. It collects the core's byte output stream and reassembles it into 32-bit ciphertext words, flagging the last word of each 64-byte block. It sits between a word-wide host bus and the core's 8-bit pin-level interface, driving the core's data-in, valid-in, key/mode and ready-in pins and consuming its data-out, valid-out and ready-out pins.

## Interface
- BLOCK_WORDS, 16, ciphertext words per keystream block; out_last marks word BLOCK_WORDS-1. Power of two, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: drops partial TX/RX words and clears the block counter.
- in_word  in  32  word to send.
- in_key  in  1  1 = key word (core mode pin high for all 4 bytes), 0 = data word.
- in_valid  in  1  word-side request.
- in_ready  out  1  word accepted when in_valid & in_ready.
- tx_byte  out  8  byte to core.
- tx_key  out  1  core mode pin; held stable for the whole word.
- tx_valid  out  1  byte valid to core.
- tx_ready  in  1  core ready; byte transfers when tx_valid & tx_ready.
- rx_byte  in  8  byte from core.
- rx_valid  in  1  core output valid.
- rx_ready  out  1  host ready for core output byte.
- out_word  out  32  reassembled ciphertext word.
- out_valid  out  1  out_word valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_last  out  1  qualifies out_valid: final word of a block.

## Operation
- TX FSM: IDLE, SEND.
  - IDLE: in_ready=1. On accept, latch in_word into a 32-bit shift register, latch in_key, clear byte index, go to SEND.
  - SEND: tx_valid=1, tx_byte=shift[7:0], tx_key=latched key. On each tx handshake, shift right 8 and increment the index. After the handshake with index 3, return to IDLE.
  - tx_byte, tx_valid and tx_key are registered outputs.
- RX assembler: states COLLECT and HOLD.
  - COLLECT: rx_ready=1. Each rx handshake writes rx_byte into byte lane idx (lane 0 = bits 7:0) and increments idx. On the 4th byte, go to HOLD.
  - HOLD: out_valid=1, rx_ready=0. On out_ready, return to COLLECT, clear idx, and increment word counter modulo BLOCK_WORDS.
- out_last = out_valid & (word counter == BLOCK_WORDS-1).
- Word counter also clears when a key word is accepted, so a new key always starts a fresh block.
- TX and RX paths run fully independently. Simultaneous tx and rx handshakes in one cycle are both honored.
- flush overrides every other input:
  - TX goes to IDLE; RX goes to COLLECT with idx=0; counter is cleared.
  - No handshake completes in the flush cycle; in_ready, rx_ready and out_valid are forced to 0 that cycle.
- Key-then-data sequencing and waiting for ciphertext are the host's responsibility. The block does not interlock TX against RX.

## Timing
- Reset values:
  - in_ready=1, tx_valid=0, tx_byte=0, tx_key=0.
  - rx_ready=1, out_valid=0, out_word=0, out_last=0.
  - All counters and indices 0.
- TX latency: word accepted in cycle N; byte 0 valid from N+1. With tx_ready held high, bytes 0..3 transfer in N+1..N+4 and in_ready returns at N+5. Peak rate is one word per 5 cycles.
- RX latency: 4th byte accepted in cycle M gives out_valid in cycle M+1. rx_ready is low from M+1 until the cycle after the out handshake.
- tx_ready low stalls SEND with tx_byte and tx_key stable. out_ready low stalls HOLD with out_word stable.
- Counter wrap: after word BLOCK_WORDS-1 is consumed, the next word has counter 0.
- Asynchronous reset mid-word discards all partial state immediately.

## Structure
- Shared package chacha_pkg holds the byte width (8), word width (32), bytes-per-word (4) and default BLOCK_WORDS. It also holds the TX and RX state enums.
- One natural sub-module: chacha_rx_packer (byte→word assembler with HOLD). The TX serializer and word counter stay in the top.

## Test plan
- Single data word 0xA1B2C3D4, in_key=0, tx_ready=1 → tx_byte sequence D4,C3,B2,A1 in cycles N+1..N+4, tx_key=0 throughout, in_ready high again at N+5.
- Key word 0x03020100 with tx_ready toggling 1,0,1,0 → each byte is held through stalls and transferred exactly once, in order 00,01,02,03, with tx_key=1 on all four.
- RX bytes 11,22,33,44 back-to-back → out_word=0x44332211 valid one cycle after byte 44. rx_ready stays 0 while out_ready=0 for 3 cycles, then one word is consumed.
- 16 RX words with BLOCK_WORDS=16 → out_last=1 only on word 15. Word 16 shows out_last=0 (counter wrapped).
- flush asserted after 2 of 4 TX bytes and 3 of 4 RX bytes → TX goes IDLE and the remaining bytes are not sent. The next 4 RX bytes form a complete new word. A fresh key word clears the block counter.
- Asynchronous reset pulse mid-SEND while in_valid stays high → outputs take their reset values immediately. The word is re-accepted from byte 0 after reset is released.
